// File: rtl/msrv_32_pkg.sv
// Shared encodings for the msrv_32 PC-select path: PC mux selects and
// the PC sequencer FSM states.
package msrv_32_pkg;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NEXT = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_TRAP = 2'b10,
    ST_MRET = 2'b11
  } state_t;

endpackage

// File: rtl/msrv_32_fetch_wdt.sv
// Fetch watchdog: counts consecutive not-ready bus cycles while the core is
// fetching and fires once the run reaches TIMEOUT, then starts over.
module msrv_32_fetch_wdt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  output logic fire,
  output logic pulse
);

  localparam logic [9:0] LAST = 10'(TIMEOUT - 1);

  logic [9:0] cnt;

  // Fires during the TIMEOUT-th consecutive stalled cycle so the FSM can
  // redirect on that same edge.
  assign fire = active && !ready && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= fire;
      if (!active || ready || fire) begin
        cnt <= '0;
      end else if (cnt != 10'h3ff) begin
        cnt <= cnt + 10'd1;
      end
    end
  end

endmodule

// File: rtl/msrv_32_pc_ctrl.sv
// PC-select sequencer for msrv_32: boot, fetch, trap entry and mret.
// Define MSRV32_FETCH_WDT_EN to add the fetch-bus watchdog trap source.
module msrv_32_pc_ctrl
  import msrv_32_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       ahb_ready_in,
  input  logic       trap_req_in,
  input  logic       mret_req_in,
  input  logic       misaligned_instr_in,
  output logic [1:0] pc_src_out,
  output logic       pc_we_out,
  output logic       flush_out,
  output logic       trap_ack_out,
  output logic       mret_ack_out,
  output logic       bus_timeout_out,
  output logic [1:0] state_out
);

  if (BOOT_CYCLES < 1 || BOOT_CYCLES > 15) begin : g_bad_boot_cycles
    $error("BOOT_CYCLES must be in 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..1023");
  end

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t     state, next_state;
  logic [3:0] boot_cnt;
  logic       boot_done;
  logic       wdt_fire;
  logic       trap_src;

`ifdef MSRV32_FETCH_WDT_EN
  msrv_32_fetch_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_fetch_wdt (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .active(state != ST_BOOT),
    .ready (ahb_ready_in),
    .fire  (wdt_fire),
    .pulse (bus_timeout_out)
  );
`else
  assign wdt_fire        = 1'b0;
  assign bus_timeout_out = 1'b0;
`endif

  assign boot_done = (boot_cnt == BOOT_LAST);
  assign trap_src  = trap_req_in || misaligned_instr_in || wdt_fire;
  assign state_out = state;

  always_comb begin
    pc_src_out = PC_SRC_BOOT;
    pc_we_out  = 1'b0;
    flush_out  = 1'b1;
    next_state = state;
    case (state)
      ST_BOOT: begin
        pc_we_out = ahb_ready_in && boot_done;
        if (ahb_ready_in && boot_done) next_state = ST_RUN;
      end
      ST_RUN: begin
        pc_src_out = PC_SRC_NEXT;
        // A trap source outranks a concurrent mret; the mret is seen again
        // once the trap handler entry has returned to RUN.
        if (trap_src) begin
          next_state = ST_TRAP;
        end else if (mret_req_in) begin
          next_state = ST_MRET;
        end else begin
          pc_we_out = ahb_ready_in;
          flush_out = 1'b0;
        end
      end
      ST_TRAP: begin
        pc_src_out = PC_SRC_TRAP;
        pc_we_out  = ahb_ready_in;
        if (ahb_ready_in) next_state = ST_RUN;
      end
      ST_MRET: begin
        pc_src_out = PC_SRC_EPC;
        pc_we_out  = ahb_ready_in;
        if (ahb_ready_in) next_state = ST_RUN;
      end
      default: next_state = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= ST_BOOT;
      boot_cnt     <= '0;
      trap_ack_out <= 1'b0;
      mret_ack_out <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_BOOT && boot_cnt < BOOT_LAST) boot_cnt <= boot_cnt + 4'd1;
      trap_ack_out <= (state == ST_TRAP) && ahb_ready_in;
      mret_ack_out <= (state == ST_MRET) && ahb_ready_in;
    end
  end

endmodule

// File: tb/tb_msrv_32_pc_ctrl.sv
// Bench for msrv_32_pc_ctrl: directed test-plan sequences then random
// traffic, scored per cycle against a cycle-level behavioural model.
module tb_msrv_32_pc_ctrl;

  localparam int BOOT_CYCLES = 2;
`ifdef MSRV32_FETCH_WDT_EN
  localparam int TIMEOUT = 4;
  localparam bit WDT_EN  = 1'b1;
`else
  localparam int TIMEOUT = 255;
  localparam bit WDT_EN  = 1'b0;
`endif

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_TRAP = 2;
  localparam int M_MRET = 3;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       ahb_ready_in, trap_req_in, mret_req_in, misaligned_instr_in;
  logic [1:0] pc_src_out, state_out;
  logic       pc_we_out, flush_out, trap_ack_out, mret_ack_out, bus_timeout_out;

  msrv_32_pc_ctrl #(
    .BOOT_CYCLES(BOOT_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .ahb_ready_in       (ahb_ready_in),
    .trap_req_in        (trap_req_in),
    .mret_req_in        (mret_req_in),
    .misaligned_instr_in(misaligned_instr_in),
    .pc_src_out         (pc_src_out),
    .pc_we_out          (pc_we_out),
    .flush_out          (flush_out),
    .trap_ack_out       (trap_ack_out),
    .mret_ack_out       (mret_ack_out),
    .bus_timeout_out    (bus_timeout_out),
    .state_out          (state_out)
  );

  // clock
  always #5 clk_in = ~clk_in;

  // scoreboard: {state, pc_src, pc_we, flush, trap_ack, mret_ack, timeout}
  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // reference model: phase of the core plus elapsed-cycle counters
  int mode     = M_BOOT;
  int boot_n   = 0;
  int stall_n  = 0;
  bit ack_t    = 1'b0;
  bit ack_m    = 1'b0;
  bit to_pulse = 1'b0;

  task automatic cycle(input bit rst, input bit rdy, input bit trp, input bit mrt, input bit mis);
    int  src, nxt;
    bit  we, fl, fire;
    @(posedge clk_in);
    #1;
    rst_n_in = rst; ahb_ready_in = rdy; trap_req_in = trp;
    mret_req_in = mrt; misaligned_instr_in = mis;
    cyc++;
    if (!rst) begin
      mode = M_BOOT; boot_n = 0; stall_n = 0;
      ack_t = 0; ack_m = 0; to_pulse = 0;
      exp_q.push_back({2'(M_BOOT), 2'b00, 1'b0, 1'b1, 3'b000});
      return;
    end
    fire = WDT_EN && mode != M_BOOT && !rdy && (stall_n + 1 == TIMEOUT);
    nxt = mode; src = 0; we = 0; fl = 1;
    case (mode)
      M_BOOT: begin
        we = rdy && (boot_n >= BOOT_CYCLES - 1);
        if (we) nxt = M_RUN;
      end
      M_RUN: begin
        src = 3;
        if (trp || mis || fire) nxt = M_TRAP;
        else if (mrt)           nxt = M_MRET;
        else begin we = rdy; fl = 0; end
      end
      M_TRAP: begin src = 2; we = rdy; if (rdy) nxt = M_RUN; end
      default: begin src = 1; we = rdy; if (rdy) nxt = M_RUN; end
    endcase
    exp_q.push_back({2'(mode), 2'(src), we, fl, ack_t, ack_m, to_pulse});
    ack_t    = (mode == M_TRAP) && rdy;
    ack_m    = (mode == M_MRET) && rdy;
    to_pulse = fire;
    stall_n  = (mode == M_BOOT || rdy || fire) ? 0 : stall_n + 1;
    if (mode == M_BOOT) boot_n++;
    mode = nxt;
  endtask

  // monitor
  initial begin
    logic [8:0] exp, act;
    forever begin
      @(negedge clk_in);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        act = {state_out, pc_src_out, pc_we_out, flush_out,
               trap_ack_out, mret_ack_out, bus_timeout_out};
        n_checks++;
        if (act !== exp) begin
          n_errors++;
          $display("FAIL outputs cyc=%0d got {st,src,we,fl,tack,mack,to}=%b_%b_%b_%b_%b_%b_%b required %b_%b_%b_%b_%b_%b_%b",
                   cyc, act[8:7], act[6:5], act[4], act[3], act[2], act[1], act[0],
                   exp[8:7], exp[6:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst_n_in = 1'b0; ahb_ready_in = 1'b0; trap_req_in = 1'b0;
    mret_req_in = 1'b0; misaligned_instr_in = 1'b0;

    // reset, then boot with ready high and a few RUN cycles
    cycle(0, 1, 0, 0, 0); cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);

    // ready toggling in RUN
    cycle(1, 1, 0, 0, 0); cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0); cycle(1, 1, 0, 0, 0);

    // trap and mret together: trap wins, mret re-evaluated afterwards
    cycle(1, 1, 1, 1, 0); cycle(1, 1, 1, 1, 0);
    cycle(1, 1, 0, 1, 0); cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0); cycle(1, 1, 0, 0, 0);

    // mret stalled three cycles in MRET
    cycle(1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 0);
    cycle(1, 1, 0, 1, 0); cycle(1, 1, 0, 0, 0); cycle(1, 1, 0, 0, 0);

    // misaligned target as a trap source, request dropped inside TRAP
    cycle(1, 1, 0, 0, 1); cycle(1, 0, 0, 0, 0); cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);

    // reset asserted mid-TRAP with ready low; no ack after release
    cycle(1, 1, 1, 0, 0); cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0); cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0);

    // boot held on the last count while ready is low
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0);

`ifdef MSRV32_FETCH_WDT_EN
    // watchdog timeout in RUN, then a timeout while stalled in TRAP
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0);
    end

    @(negedge clk_in);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain got %0d pending entries required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/msrv_32_pc_ctrl.md
Name: msrv_32_pc_ctrl

Overview:
- Sequencer for the PC-select datapath of the msrv_32 core.
- Owns the 2-bit PC-source select and PC-register write enable, and the pipeline flush.
- Walks the core through boot, normal fetch, trap entry and trap return (mret), and stalls on the AHB instruction-bus ready.
- Sits between the machine-control/CSR unit (trap/mret requests) and the PC mux plus PC register.

Parameters:
- BOOT_CYCLES, 2: cycles the boot vector (pc_src=00) is presented after reset release; legal 1..15.
- TIMEOUT, 255: consecutive not-ready bus cycles before a timeout trap (only with the optional feature); legal 1..1023.

Ports:
- clk_in  input  1  core clock; all state updates on its rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- ahb_ready_in  input  1  instruction-bus ready; 0 = stall.
- trap_req_in  input  1  exception/interrupt taken; level, held until trap_ack_out.
- mret_req_in  input  1  mret executed; level, held until mret_ack_out.
- misaligned_instr_in  input  1  misaligned branch target from the PC mux; trap source.
- pc_src_out  output  2  00 boot vector, 01 epc, 10 trap vector, 11 sequential/branch.
- pc_we_out  output  1  PC register load enable.
- flush_out  output  1  kill the instruction in decode.
- trap_ack_out  output  1  one-cycle pulse; trap vector loaded.
- mret_ack_out  output  1  one-cycle pulse; epc loaded.
- bus_timeout_out  output  1  one-cycle pulse; fetch watchdog fired (tied 0 without the feature).
- state_out  output  2  debug view of the FSM state: BOOT=00, RUN=01, TRAP=10, MRET=11.

Behaviour:
- Reset (asynchronous, rst_n_in=0):
  - State=BOOT, boot counter=0, watchdog counter=0.
  - Registered outputs are 0: trap_ack_out, mret_ack_out, bus_timeout_out.
  - Decoded outputs take their BOOT values: pc_src_out=00, pc_we_out=0, flush_out=1, state_out=00.
  - Reset asserted mid-operation in any state aborts that state immediately. Pending requests are not remembered.
- Output timing: pc_src_out, pc_we_out, flush_out and state_out are combinational decodes of state and inputs. The ack and timeout pulses are registered.
- BOOT:
  - pc_src=00, flush=1.
  - Boot counter increments each cycle while below BOOT_CYCLES-1.
  - pc_we = ahb_ready_in AND (counter = BOOT_CYCLES-1).
  - When pc_we=1, go to RUN. If ahb_ready_in=0 on the last count, hold in BOOT.
- RUN:
  - pc_src=11.
  - Trap sources are trap_req_in, misaligned_instr_in, and the internal timeout.
  - Any trap source active: pc_we=0, flush=1, next state TRAP. Priority: trap source > mret.
  - Else mret_req_in=1: pc_we=0, flush=1, next state MRET.
  - Else: pc_we = ahb_ready_in, flush=0.
- TRAP:
  - pc_src=10, flush=1, pc_we = ahb_ready_in.
  - When ahb_ready_in=1: trap_ack_out pulses on the next edge, state goes to RUN.
  - New requests are ignored until back in RUN.
- MRET:
  - pc_src=01, flush=1, pc_we = ahb_ready_in.
  - When ahb_ready_in=1: mret_ack_out pulses, state goes to RUN.
- Simultaneous trap and mret in RUN: trap taken, mret_ack_out not pulsed. The mret is re-evaluated when RUN is re-entered, if mret_req_in is still high.
- Request dropped before ack while in TRAP/MRET: the sequence still completes (committed on state entry).
- Counter widths: boot counter 4 bits, watchdog 10 bits. Counters saturate and never wrap.

Optional Feature:
- Macro: MSRV32_FETCH_WDT_EN.
- Defined:
  - The watchdog counts consecutive cycles with ahb_ready_in=0 in RUN/TRAP/MRET and clears on any ready=1.
  - On reaching TIMEOUT it pulses bus_timeout_out for one cycle, clears, and acts as a trap source in RUN.
  - In TRAP/MRET a timeout pulses only; no state change.
- Undefined: no counter logic; bus_timeout_out tied 0; the timeout trap source is absent.

Decomposition:
- Shared package msrv_32_pkg holds:
  - PC_SRC_BOOT=2'b00, PC_SRC_EPC=2'b01, PC_SRC_TRAP=2'b10, PC_SRC_NEXT=2'b11.
  - FSM state encodings ST_BOOT, ST_RUN, ST_TRAP, ST_MRET.
- One sub-module, msrv_32_fetch_wdt: the saturating watchdog counter, instantiated only under MSRV32_FETCH_WDT_EN.

Test Plan:
- Reset released with BOOT_CYCLES=2 and ready=1 -> pc_src=00, pc_we=0 then 1 on 2nd cycle; then state=RUN, pc_src=11, pc_we=1 each cycle.
- RUN with ready toggling 1,0,0,1 -> pc_we follows ready exactly; flush=0; state stays RUN.
- trap_req_in=1 and mret_req_in=1 in the same RUN cycle, ready=1 -> one cycle pc_we=0/flush=1, then pc_src=10/pc_we=1; trap_ack_out pulses once; mret_ack_out stays 0.
- mret_req_in=1 with ready held 0 for 3 cycles in MRET -> pc_src=01, pc_we=0 for 3 cycles; on ready=1 pc_we=1, then mret_ack_out pulse, state RUN.
- Reset asserted mid-TRAP (ready=0) -> outputs immediately at BOOT values (pc_src=00, flush=1, acks=0); no trap_ack_out after release.
- With MSRV32_FETCH_WDT_EN and TIMEOUT=4, ready=0 for 4 RUN cycles -> bus_timeout_out pulse on the 4th, then state TRAP, pc_src=10.
